// File: rtl/falco_harness_ctrl_if.sv
// Host/core-facing signal bundle for the test harness run controller.
// Master drives requests and commits; slave is the controller.
interface falco_harness_ctrl_if #(
    parameter int COMMIT_W = 2,
    parameter int RET_W    = 48
);
    logic                start;
    logic                abort;
    logic [RET_W-1:0]    budget;
    logic [COMMIT_W-1:0] commit_count;
    logic                core_rst;
    logic                running;
    logic                done;
    logic [1:0]          status;
    logic [RET_W-1:0]    retired;
    logic [RET_W-1:0]    cycle_cnt;

    modport master (
        output start,
        output abort,
        output budget,
        output commit_count,
        input  core_rst,
        input  running,
        input  done,
        input  status,
        input  retired,
        input  cycle_cnt
    );

    modport slave (
        input  start,
        input  abort,
        input  budget,
        input  commit_count,
        output core_rst,
        output running,
        output done,
        output status,
        output retired,
        output cycle_cnt
    );
endinterface

// File: rtl/falco_harness_ctrl.sv
// Run controller: holds the core in reset, runs it, stops on budget/watchdog/abort.
// Define FALCO_HARNESS_CYCLE_CNT_EN to build the RUN-cycle counter.
module falco_harness_ctrl #(
    parameter int COMMIT_W   = 2,
    parameter int RST_CYCLES = 4,
    parameter int WDOG_W     = 16,
    parameter int RET_W      = 48
) (
    input  logic                clk,
    input  logic                rst,
    falco_harness_ctrl_if.slave bus
);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    // One below all-ones: the next idle cycle reaches the timeout.
    localparam logic [WDOG_W-1:0] WDOG_PRE = ~WDOG_W'(1);

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_BUDGET = 2'd1;
    localparam logic [1:0] ST_WDOG   = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [RET_W-1:0]  budget_q, budget_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic [1:0]        status_q, status_d;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;

    logic [RET_W:0]    sum;
    logic [RET_W-1:0]  sum_sat;
    logic              commit_nz;
    logic              budget_hit;
    logic              wdog_hit;
    logic              accept;

    assign accept    = bus.start && (state_q == IDLE || state_q == STOP);
    assign sum       = {1'b0, retired_q} + (RET_W+1)'(bus.commit_count);
    assign sum_sat   = sum[RET_W] ? '1 : sum[RET_W-1:0];
    assign commit_nz = |bus.commit_count;
    // Compare the unsaturated sum so a budget near the top still triggers.
    assign budget_hit = (|budget_q) && (sum >= {1'b0, budget_q});
    assign wdog_hit   = !commit_nz && (wdog_q == WDOG_PRE);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wdog_d    = wdog_q;
        budget_d  = budget_q;
        retired_d = retired_q;
        status_d  = status_q;
        unique case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d   = HOLD;
                    hold_d    = '0;
                    wdog_d    = '0;
                    budget_d  = bus.budget;
                    retired_d = '0;
                    status_d  = ST_NONE;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                retired_d = sum_sat;
                wdog_d    = commit_nz ? '0 : wdog_q + 1'b1;
                if (budget_hit) begin
                    state_d  = STOP;
                    status_d = ST_BUDGET;
                end else if (wdog_hit) begin
                    state_d  = STOP;
                    status_d = ST_WDOG;
                end else if (bus.abort) begin
                    state_d  = STOP;
                    status_d = ST_ABORT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            wdog_q     <= '0;
            budget_q   <= '0;
            retired_q  <= '0;
            status_q   <= ST_NONE;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wdog_q     <= wdog_d;
            budget_q   <= budget_d;
            retired_q  <= retired_d;
            status_q   <= status_d;
            core_rst_q <= (state_d != RUN);
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == STOP) && (state_q != STOP);
        end
    end

`ifdef FALCO_HARNESS_CYCLE_CNT_EN
    logic [RET_W-1:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (accept) begin
            cyc_q <= '0;
        end else if (state_q == RUN && !(&cyc_q)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign bus.cycle_cnt = cyc_q;
`else
    assign bus.cycle_cnt = '0;
`endif

    assign bus.core_rst = core_rst_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.status   = status_q;
    assign bus.retired  = retired_q;
endmodule

// File: doc/falco_harness_ctrl.md
FALCO_HARNESS_CTRL -- requirements
Module: falco_harness_ctrl

Interface
REQ-001 SHALL have parameter COMMIT_W, default 2, width of per-cycle commit count.
REQ-002 SHALL have parameter RST_CYCLES, default 4, core reset hold length in cycles (>=1).
REQ-003 SHALL have parameter WDOG_W, default 16, watchdog width; timeout = 2^WDOG_W-1 cycles without a commit.
REQ-004 SHALL have parameter RET_W, default 48, retired-instruction counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-008 SHALL have port abort  input  1  host request to stop current run.
REQ-009 SHALL have port budget  input  RET_W  instruction budget, sampled on accepted start; 0 = unlimited.
REQ-010 SHALL have port commit_count  input  COMMIT_W  instructions committed by core this cycle.
REQ-011 SHALL have port core_rst  output  1  registered reset to core and memory model.
REQ-012 SHALL have port running  output  1  high while state is RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse on entry to STOP.
REQ-014 SHALL have port status  output  2  0 none, 1 budget reached, 2 watchdog timeout, 3 aborted.
REQ-015 SHALL have port retired  output  RET_W  instructions retired in current/last run.
REQ-016 SHALL have port cycle_cnt  output  RET_W  RUN cycles in current/last run.

Function
REQ-017 SHALL implement states IDLE, HOLD, RUN, STOP; all outputs registered.
REQ-018 SHALL assert core_rst in IDLE, HOLD, STOP; deassert only in RUN.
REQ-019 IDLE/STOP + start -> HOLD; clears retired, cycle_cnt, watchdog, status; latches budget.
REQ-020 HOLD SHALL last exactly RST_CYCLES cycles, then -> RUN; core_rst falls on first RUN cycle.
REQ-021 start in HOLD or RUN SHALL be ignored; abort in IDLE, HOLD or STOP SHALL be ignored.
REQ-022 In RUN, retired SHALL add zero-extended commit_count each cycle, saturating at 2^RET_W-1; commits outside RUN ignored.
REQ-023 Watchdog SHALL clear on any cycle with commit_count!=0, else increment; at all-ones -> STOP, status=2.
REQ-024 With budget!=0, when retired+commit_count >= budget -> STOP, status=1; retired records the full sum (may exceed budget).
REQ-025 abort in RUN -> STOP, status=3, same cycle's commits still counted.
REQ-026 Simultaneous terminations SHALL resolve priority budget > watchdog > abort.
REQ-027 done SHALL pulse exactly one cycle coincident with first STOP cycle; status, retired, cycle_cnt held in STOP until next accepted start.
REQ-028 cycle_cnt SHALL increment once per RUN cycle, saturating.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, core_rst=1, running=0, done=0, status=0, retired=0, cycle_cnt=0, watchdog=0, latched budget=0.
REQ-030 rst asserted mid-run SHALL abort without done pulse or status update; after release state is IDLE.

Configuration
REQ-031 Macro FALCO_HARNESS_CYCLE_CNT_EN defined: cycle_cnt counter implemented per REQ-028.
REQ-032 Macro undefined: no cycle counter flops; cycle_cnt tied to 0; all else unchanged.

Verification
REQ-033 rst release, start at cycle 2 -> core_rst high for RST_CYCLES=4 HOLD cycles, low from cycle 7, running=1.
REQ-034 budget=10, commit_count=2 every RUN cycle -> STOP after 5th RUN cycle, status=1, retired=10, done one pulse, cycle_cnt=5.
REQ-035 WDOG_W=4, commit_count=0 forever -> STOP after 15 RUN cycles, status=2, core_rst re-asserted next cycle.
REQ-036 Same cycle: budget reached, abort=1 -> status=1; budget=0 with commits -> never budget-terminates.
REQ-037 rst pulse mid-RUN -> IDLE, all outputs at reset values, no done; subsequent start runs normally.
REQ-038 start while RUN -> ignored; start in STOP -> counters cleared, HOLD re-entered, status=0.
